// File: rtl/uart_transmitter.sv
// UART transmit serialiser on the 16x baud clock.
// Sends start, 5..9 data bits LSB first, optional even/odd parity and 1 or 2
// stop bits. Every serial bit is held for OVERSAMPLE clocks. The link
// configuration is captured when a frame is accepted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line at IDLE_LEVEL, ready=1, waiting for frame_valid
// S_START  | start bit (inverse of IDLE_LEVEL)
// S_DATA   | data bits, LSB first, from the latched shift register
// S_PARITY | latched parity bit
// S_STOP   | one or two stop bits at IDLE_LEVEL, then back to S_IDLE
module uart_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  input  logic       parity,
  input  logic       parity_type,
  input  logic       stop_bits,
  input  logic [3:0] frame_length,
  output logic       Tx,
  output logic       ready,
  output logic       tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      data_idx_q, data_idx_d;
  logic [8:0]      data_q, data_d;
  logic [3:0]      len_q, len_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic            stop2_q, stop2_d;
  logic            stop_idx_q, stop_idx_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            tx_done_q, tx_done_d;

  logic [3:0]      len_clamp;
  logic [8:0]      len_mask;
  logic            bit_end;

  // Clamp the requested length to 5..9 and build the matching data-bit mask.
  always_comb begin
    len_clamp = frame_length;
    if (frame_length < 4'd5) len_clamp = 4'd5;
    else if (frame_length > 4'd9) len_clamp = 4'd9;
    len_mask = '0;
    for (int i = 0; i < 9; i++) len_mask[i] = (i < int'(len_clamp));
  end

  // Next-state and next-output logic; Tx is computed one cycle ahead so it
  // leaves a flop with the same timing as the state it belongs to.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_idx_d = data_idx_q;
    data_d     = data_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    tx_done_d  = 1'b0;
    bit_end    = (bit_cnt_q == BIT_LAST);

    case (state_q)
      S_IDLE: begin
        tx_d = IDLE_LEVEL;
        if (frame_valid && ready_q) begin
          state_d    = S_START;
          tx_d       = ~IDLE_LEVEL;
          ready_d    = 1'b0;
          bit_cnt_d  = '0;
          data_idx_d = '0;
          data_d     = frame;
          len_d      = len_clamp;
          par_en_d   = parity;
          par_bit_d  = (^(frame & len_mask)) ^ parity_type;
          stop2_d    = stop_bits;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_end) begin
          state_d    = S_DATA;
          bit_cnt_d  = '0;
          data_idx_d = '0;
          tx_d       = data_q[0];
        end
      end
      S_DATA: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          if (data_idx_q == len_q - 4'd1) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              tx_d       = IDLE_LEVEL;
              stop_idx_d = 1'b0;
            end
          end else begin
            data_idx_d = data_idx_q + 4'd1;
            data_d     = data_q >> 1;
            tx_d       = data_q[1];
          end
        end
      end
      S_PARITY: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_end) begin
          state_d    = S_STOP;
          bit_cnt_d  = '0;
          tx_d       = IDLE_LEVEL;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        tx_d      = IDLE_LEVEL;
        if (bit_end) begin
          bit_cnt_d = '0;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d   = S_IDLE;
            ready_d   = 1'b1;
            tx_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = IDLE_LEVEL;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      data_idx_q <= '0;
      data_q     <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= IDLE_LEVEL;
      ready_q    <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_idx_q <= data_idx_d;
      data_q     <= data_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign Tx      = tx_q;
  assign ready   = ready_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed link formats plus random frames, each
// compared cycle by cycle against a bit list built from the frame rules.
module tb_uart_transmitter;

  localparam int OS = 16;

  logic       clk_16bd = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] frame = '0;
  logic       frame_valid = 1'b0;
  logic       parity = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop_bits = 1'b0;
  logic [3:0] frame_length = 4'd8;
  logic       Tx;
  logic       ready;
  logic       tx_done;

  int checks = 0;
  int failures = 0;
  bit exp_bits[$];

  uart_transmitter #(.OVERSAMPLE(OS), .IDLE_LEVEL(1'b1)) dut (
    .clk_16bd    (clk_16bd),
    .rst         (rst),
    .frame       (frame),
    .frame_valid (frame_valid),
    .parity      (parity),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .frame_length(frame_length),
    .Tx          (Tx),
    .ready       (ready),
    .tx_done     (tx_done)
  );

  always #5 clk_16bd = ~clk_16bd;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Serial bit list of one frame: start, N data LSB first, parity, stop(s).
  task automatic build_frame(input logic [8:0] fr, input int len, input bit par,
                             input bit pt, input bit sb);
    int n;
    int ones;
    n = (len < 5) ? 5 : (len > 9) ? 9 : len;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(fr[i]);
      ones += int'(fr[i]);
    end
    if (par) exp_bits.push_back(bit'(ones % 2) ^ pt);
    exp_bits.push_back(1'b1);
    if (sb) exp_bits.push_back(1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_16bd);
      chk("idle_tx", 9'(Tx), 9'd1);
      chk("idle_ready", 9'(ready), 9'd1);
      chk("idle_done", 9'(tx_done), 9'd0);
    end
  endtask

  // Called at a negedge with the DUT idle. Accepts one frame, scrambles the
  // inputs while it is in flight, and ends at the negedge showing tx_done.
  // hold keeps frame_valid high throughout; otherwise a stray pulse is sent.
  task automatic run_frame(input logic [8:0] fr, input int len, input bit par,
                           input bit pt, input bit sb, input bit hold);
    int total;
    int pulse_at;
    build_frame(fr, len, par, pt, sb);
    total = exp_bits.size() * OS;
    pulse_at = int'($urandom_range(0, total - 3));
    frame = fr;
    frame_length = 4'(len);
    parity = par;
    parity_type = pt;
    stop_bits = sb;
    frame_valid = 1'b1;
    @(posedge clk_16bd);
    #1;
    frame_valid = hold;
    frame = 9'($urandom);
    frame_length = 4'($urandom);
    parity = 1'($urandom);
    parity_type = 1'($urandom);
    stop_bits = 1'($urandom);
    for (int j = 0; j < total; j++) begin
      @(negedge clk_16bd);
      chk("tx_bit", 9'(Tx), 9'(exp_bits[j / OS]));
      chk("busy_ready", 9'(ready), 9'd0);
      chk("busy_done", 9'(tx_done), 9'd0);
      frame_valid = hold || (j == pulse_at);
    end
    @(negedge clk_16bd);
    chk("end_done", 9'(tx_done), 9'd1);
    chk("end_ready", 9'(ready), 9'd1);
    chk("end_tx", 9'(Tx), 9'd1);
  endtask

  initial begin
    // Reset held for 3 cycles, then a quiet line.
    repeat (3) @(negedge clk_16bd);
    chk("rst_tx", 9'(Tx), 9'd1);
    chk("rst_ready", 9'(ready), 9'd1);
    chk("rst_done", 9'(tx_done), 9'd0);
    rst = 1'b1;
    idle_cycles(50);

    run_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0);  // 8N1
    idle_cycles(3);
    run_frame(9'h041, 7, 1'b1, 1'b0, 1'b0, 1'b0);  // 7E1
    idle_cycles(2);
    run_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0);  // 7O2
    idle_cycles(2);
    run_frame(9'h1FF, 9, 1'b0, 1'b0, 1'b0, 1'b0);  // 9 data ones
    idle_cycles(1);
    run_frame(9'h1B6, 3, 1'b1, 1'b0, 1'b0, 1'b0);  // clamps to 5
    idle_cycles(1);
    run_frame(9'h15A, 15, 1'b1, 1'b1, 1'b1, 1'b0); // clamps to 9

    // Back-to-back with frame_valid held high.
    run_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(9'h13C, 9, 1'b1, 1'b0, 1'b1, 1'b1);
    run_frame(9'h01E, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(2);

    // Random frames, random lengths including out-of-range values.
    for (int k = 0; k < 14; k++) begin
      bit hold;
      hold = (k % 4 == 3);
      run_frame(9'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                1'($urandom), 1'($urandom), hold);
      if (!hold) idle_cycles(int'($urandom_range(1, 4)));
    end
    frame_valid = 1'b0;
    idle_cycles(2);

    // Reset during the low data bit 3 of 9'h0A5 (8N1).
    frame = 9'h0A5;
    frame_length = 4'd8;
    parity = 1'b0;
    stop_bits = 1'b0;
    frame_valid = 1'b1;
    @(posedge clk_16bd);
    #1;
    frame_valid = 1'b0;
    repeat (70) @(negedge clk_16bd);
    chk("pre_rst_tx", 9'(Tx), 9'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_tx", 9'(Tx), 9'd1);
    chk("async_rst_ready", 9'(ready), 9'd1);
    chk("async_rst_done", 9'(tx_done), 9'd0);
    @(negedge clk_16bd);
    rst = 1'b1;
    idle_cycles(3);
    run_frame(9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
